// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the configurable up/down counter.
// Holds mode/direction encodings used by mod_counter and mod_counter_next.
package mod_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count calculator: applies step/dir/limits/mode.
// Ports: count, step, dir, min_i, max_i, mode in; next_o, crossed_o, in_range_o out.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int NBITS = 16
) (
  input  logic [NBITS-1:0] count,
  input  logic [NBITS-1:0] step,
  input  logic             dir,
  input  logic [NBITS-1:0] min_i,
  input  logic [NBITS-1:0] max_i,
  input  mode_e            mode,
  output logic [NBITS-1:0] next_o,
  output logic             crossed_o,
  output logic             in_range_o
);

  localparam int W = NBITS + 2;
  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] c, s, lo, hi, span, n, res;

  // Two guard bits so sums and differences never truncate.
  assign c    = {2'b00, count};
  assign s    = {2'b00, step};
  assign lo   = {2'b00, min_i};
  assign hi   = {2'b00, max_i};
  assign span = hi - lo + ONE;
  assign n    = c + s;

  assign in_range_o = (c >= lo) && (c <= hi);

  always_comb begin
    res       = c;
    crossed_o = 1'b0;
    if (s == '0) begin
      res = c;
    end else if (!in_range_o) begin
      // Out-of-range start counts as a crossing into the far limit.
      res       = (dir == DIR_UP) ? lo : hi;
      crossed_o = 1'b1;
    end else if (dir == DIR_UP) begin
      if (n <= hi) begin
        res = n;
      end else begin
        crossed_o = 1'b1;
        if (mode == MODE_SAT)
          res = hi;
        else if (s > span)
          res = lo;
        else
          res = lo + (n - hi - ONE);
      end
    end else begin
      if (c >= lo + s) begin
        res = c - s;
      end else begin
        crossed_o = 1'b1;
        if (mode == MODE_SAT)
          res = lo;
        else if (s > span)
          res = hi;
        else
          res = hi - (lo + s - c - ONE);
      end
    end
  end

  assign next_o = res[NBITS-1:0];

endmodule

// File: rtl/mod_counter.sv
// Runtime-configurable up/down counter with wrap/saturate, load and match.
// Ports: clk, rst, clr, load, load_val, en, dir, step, min_i, max_i, cmp_i in;
//        count, wrap_o, sat_o, match_o, err_o out (all registered).
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int NBITS    = 16,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [NBITS-1:0] step,
  input  logic [NBITS-1:0] min_i,
  input  logic [NBITS-1:0] max_i,
  input  logic [NBITS-1:0] cmp_i,
  output logic [NBITS-1:0] count,
  output logic             wrap_o,
  output logic             sat_o,
  output logic             match_o,
  output logic             err_o
);

  localparam mode_e MODE = (SAT_MODE != 0) ? MODE_SAT : MODE_WRAP;

  logic [NBITS-1:0] count_q, count_d, nxt;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             crossed, in_range, cfg_err;

  mod_counter_next #(
    .NBITS (NBITS)
  ) u_next (
    .count      (count_q),
    .step       (step),
    .dir        (dir),
    .min_i      (min_i),
    .max_i      (max_i),
    .mode       (MODE),
    .next_o     (nxt),
    .crossed_o  (crossed),
    .in_range_o (in_range)
  );

  assign cfg_err = (min_i > max_i);

  // Priority clr > load > en; rst handled in the register.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    match_d = 1'b0;
    err_d   = cfg_err;
    if (clr) begin
      count_d = min_i;
      match_d = (min_i == cmp_i);
    end else if (load) begin
      count_d = load_val;
      match_d = (load_val == cmp_i);
    end else if (en && !cfg_err) begin
      count_d = nxt;
      wrap_d  = crossed && (MODE == MODE_WRAP);
      sat_d   = crossed && (MODE == MODE_SAT);
      // Fire only on arrival at cmp_i, not while sitting on it.
      match_d = (nxt == cmp_i) && (nxt != count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign count   = count_q;
  assign wrap_o  = wrap_q;
  assign sat_o   = sat_q;
  assign match_o = match_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: wrap and saturate instances, NBITS=8.
// Shared stimulus drives both instances; expectations hand-computed.
module tb_mod_counter;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst, clr, load, en, dir;
  logic [NB-1:0] load_val, step, min_i, max_i, cmp_i;

  logic [NB-1:0] cnt_w, cnt_s;
  logic          wrap_w, sat_w, match_w, err_w;
  logic          wrap_s, sat_s, match_s, err_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mod_counter #(.NBITS(NB), .SAT_MODE(0)) u_w (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .step(step), .min_i(min_i), .max_i(max_i),
    .cmp_i(cmp_i), .count(cnt_w), .wrap_o(wrap_w), .sat_o(sat_w),
    .match_o(match_w), .err_o(err_w)
  );

  mod_counter #(.NBITS(NB), .SAT_MODE(1)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .step(step), .min_i(min_i), .max_i(max_i),
    .cmp_i(cmp_i), .count(cnt_s), .wrap_o(wrap_s), .sat_o(sat_s),
    .match_o(match_s), .err_o(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; clr = 0; load = 0; en = 0; dir = 0;
    load_val = 0; step = 0; min_i = 0; max_i = 0; cmp_i = 200;
    tick();
    chk("rst_cnt", cnt_w, 0);
    chk("rst_wrap", wrap_w, 0);
    chk("rst_sat", sat_s, 0);
    chk("rst_match", match_w, 0);
    chk("rst_err", err_w, 0);

    // 1. wrap up
    rst = 0; min_i = 10; max_i = 20; step = 3; dir = 0;
    load = 1; load_val = 19;
    tick();
    chk("t1_load", cnt_w, 19);
    load = 0; en = 1;
    tick();
    chk("t1_cnt", cnt_w, 11);
    chk("t1_wrap", wrap_w, 1);
    chk("t1_sat_cnt", cnt_s, 20);
    chk("t1_sat", sat_s, 1);
    en = 0;
    tick();
    chk("t1_wrap_clr", wrap_w, 0);
    chk("t1_hold", cnt_w, 11);

    // step larger than span clamps to min
    load = 1; load_val = 15;
    tick();
    load = 0; en = 1; step = 12;
    tick();
    chk("big_cnt", cnt_w, 10);
    chk("big_wrap", wrap_w, 1);
    en = 0;

    // 2. saturate down
    load = 1; load_val = 12; step = 5; dir = 1;
    tick();
    load = 0; en = 1;
    tick();
    chk("t2_cnt", cnt_s, 10);
    chk("t2_sat", sat_s, 1);
    chk("t2_wcnt", cnt_w, 18);
    chk("t2_wwrap", wrap_w, 1);
    tick();
    chk("t2_cnt2", cnt_s, 10);
    chk("t2_sat2", sat_s, 1);
    chk("t2_wcnt2", cnt_w, 13);
    chk("t2_wwrap2", wrap_w, 0);

    // 3. priority
    min_i = 5; dir = 0; step = 3;
    clr = 1; load = 1; load_val = 50; en = 1;
    tick();
    chk("t3_cnt", cnt_w, 5);
    chk("t3_wrap", wrap_w, 0);
    chk("t3_sat", sat_s, 0);
    rst = 1;
    tick();
    chk("t3_rst", cnt_w, 0);
    rst = 0; clr = 0; load = 0; en = 0;

    // 4. reset mid-run
    min_i = 10; max_i = 20; step = 3; dir = 0;
    load = 1; load_val = 19;
    tick();
    load = 0; en = 1;
    tick();
    chk("t4_wrap_pre", wrap_w, 1);
    rst = 1;
    tick();
    chk("t4_cnt", cnt_w, 0);
    chk("t4_wrap", wrap_w, 0);
    chk("t4_sat", sat_s, 0);
    chk("t4_match", match_w, 0);
    rst = 0; en = 0;

    // 5. match
    cmp_i = 15; step = 1;
    load = 1; load_val = 14;
    tick();
    chk("t5_m0", match_w, 0);
    load = 0; en = 1;
    tick();
    chk("t5_cnt", cnt_w, 15);
    chk("t5_m1", match_w, 1);
    tick();
    chk("t5_m2", match_w, 0);
    en = 0; load = 1; load_val = 15;
    tick();
    chk("t5_mload", match_w, 1);
    load = 0; en = 1; step = 0;
    tick();
    chk("t5_step0", match_w, 0);
    chk("t5_hold", cnt_w, 15);

    // 6. config error
    min_i = 30; max_i = 20; step = 1;
    tick();
    chk("t6_err", err_w, 1);
    chk("t6_hold", cnt_w, 15);
    min_i = 0;
    tick();
    chk("t6_err0", err_w, 0);
    chk("t6_resume", cnt_w, 16);
    en = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
